// File: rtl/pb_eoc_pkg.sv
// pb_eoc_pkg: shared state encoding and EOC report-word helpers for the collector.
package pb_eoc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} eoc_state_e;

   localparam int unsigned EocFlagBit   = 0;
   localparam int unsigned MaxDataWidth = 64;

   typedef logic [MaxDataWidth-1:0] word_t;

   function automatic logic is_eoc(input word_t word);
      return (word & (word_t'(1) << EocFlagBit)) != '0;
   endfunction

   function automatic word_t eoc_code(input word_t word);
      return word >> (EocFlagBit + 1);
   endfunction

endpackage

// File: rtl/lzc.sv
// lzc: leading/trailing zero counter (MODE 0 = trailing, MODE 1 = leading).
module lzc #(
   parameter int unsigned WIDTH     = 2,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   // Scanning high-to-low leaves the count of the first set bit from the chosen end.
   always_comb begin
      cnt_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (in_i[MODE ? (WIDTH - 1 - i) : i]) cnt_o = CNT_WIDTH'(i);
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/pb_eoc_collector.sv
// pb_eoc_collector: gathers per-channel EOC reports under a mask and a timeout
// into one done/fail/exit-code status.
module pb_eoc_collector
   import pb_eoc_pkg::*;
#(
   parameter  int unsigned NumChannels  = 16,
   parameter  int unsigned DataWidth    = 32,
   parameter  int unsigned TimeoutWidth = 32,
   localparam int unsigned IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic [NumChannels-1:0]                ch_mask_i,
   input  logic [TimeoutWidth-1:0]               timeout_cycles_i,
   input  logic [NumChannels-1:0]                ch_valid_i,
   input  logic [NumChannels-1:0][DataWidth-1:0] ch_data_i,
   output logic [NumChannels-1:0]                ch_ready_o,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  timeout_o,
   output logic                                  fail_o,
   output logic [DataWidth-2:0]                  exit_code_o,
   output logic [IdxWidth-1:0]                   fail_idx_o,
   output logic [NumChannels-1:0]                reported_o
);

   typedef logic [DataWidth-2:0] code_t;

   eoc_state_e              state_q, state_d;
   logic [NumChannels-1:0]  mask_q, reported_q, reported_d, new_eoc, code_nz, fail_vec;
   logic [TimeoutWidth-1:0] timer_q;
   code_t                   codes_q [NumChannels];
   code_t                   codes_new [NumChannels];
   logic                    timeout_q, busy, complete, expire, arm;
   logic [IdxWidth-1:0]     lzc_idx;
   logic                    lzc_empty;

   assign busy = state_q == RUN;
   assign arm  = start_i && !busy;

   always_comb begin
      new_eoc = '0;
      code_nz = '0;
      for (int i = 0; i < NumChannels; i++) begin
         new_eoc[i]   = busy && ch_valid_i[i] && is_eoc(word_t'(ch_data_i[i])) && !reported_q[i];
         code_nz[i]   = codes_q[i] != '0;
         codes_new[i] = code_t'(eoc_code(word_t'(ch_data_i[i])));
      end
      reported_d = reported_q | new_eoc;
      // Completion looks at the post-edge reported vector so the final report finishes RUN.
      complete   = &(reported_d | ~mask_q);
      expire     = timer_q == TimeoutWidth'(1);
      state_d    = arm ? RUN : (busy && (complete || expire)) ? DONE : state_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         timer_q    <= '0;
         reported_q <= '0;
         timeout_q  <= 1'b0;
         for (int i = 0; i < NumChannels; i++) codes_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (arm) begin
            mask_q     <= ch_mask_i;
            timer_q    <= timeout_cycles_i;
            reported_q <= '0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < NumChannels; i++) codes_q[i] <= '0;
         end else if (busy) begin
            reported_q <= reported_d;
            timer_q    <= (timer_q != '0) ? timer_q - TimeoutWidth'(1) : '0;
            timeout_q  <= expire && !complete;
            for (int i = 0; i < NumChannels; i++) begin
               if (new_eoc[i]) codes_q[i] <= codes_new[i];
            end
         end
      end
   end

   assign fail_vec = mask_q & reported_q & code_nz;

   lzc #(
      .WIDTH     (NumChannels),
      .MODE      (1'b0),
      .CNT_WIDTH (IdxWidth)
   ) u_lzc (
      .in_i    (fail_vec),
      .cnt_o   (lzc_idx),
      .empty_o (lzc_empty)
   );

   assign ch_ready_o  = {NumChannels{busy}};
   assign busy_o      = busy;
   assign done_o      = state_q == DONE;
   assign timeout_o   = timeout_q;
   assign fail_o      = timeout_q || !lzc_empty;
   assign fail_idx_o  = lzc_empty ? '0 : lzc_idx;
   assign exit_code_o = lzc_empty ? '0 : codes_q[lzc_idx];
   assign reported_o  = reported_q;

endmodule
